fir_decimator: RTL
==================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter IN_WIDTH, default 9, signed sample width from the upstream FIR output.
REQ-002 Parameter DECIM, default 4, decimation ratio; power of two, 2..16.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, >=2.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  qualifies in_data; this is the FIR stage's enable/sample strobe.
REQ-007 Port in_data  input  IN_WIDTH signed  FIR output sample.
REQ-008 Port out_valid  output  1  FIFO non-empty.
REQ-009 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 Port out_data  output  IN_WIDTH signed  FIFO head, the decimated average.
REQ-011 Port overflow  output  1  sticky flag: a result was dropped.
REQ-012 Port clr_ovf  input  1  clears overflow.

Function
REQ-013 Phase counter 0..DECIM-1 advances only on cycles with in_valid=1; cycles with in_valid=0 change no datapath state.
REQ-014 Accumulator width IN_WIDTH+log2(DECIM), signed; on in_valid at phase 0 it loads in_data, at other phases it adds in_data.
REQ-015 On in_valid at phase DECIM-1: sum = acc + in_data; phase wraps to 0; a result is produced at that same edge.
REQ-016 Result = (sum + 2^(log2(DECIM)-1)) >>> log2(DECIM), i.e. round half toward +inf, arithmetic shift.
REQ-017 Result saturates to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] before truncation to IN_WIDTH.
REQ-018 Result is pushed into the FIFO at the edge ending the DECIM-th sample; out_valid rises the next cycle when the FIFO was empty (latency 1 cycle).
REQ-019 out_data always shows the FIFO head (first-word fall-through); it is stable while out_valid=1 and out_ready=0.
REQ-020 Pop occurs on cycles with out_valid=1 and out_ready=1.
REQ-021 Push while full without a same-cycle pop: result dropped, FIFO contents unchanged, overflow set at that edge.
REQ-022 Push while full with a same-cycle pop: both happen, occupancy unchanged, no overflow.
REQ-023 Push and pop on an empty FIFO: pop is not possible (out_valid=0); push proceeds.
REQ-024 clr_ovf=1 clears overflow at the next edge; a simultaneous drop takes priority and leaves overflow=1.
REQ-025 Occupancy never exceeds FIFO_DEPTH; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 While rst=1 at an edge: phase=0, acc=0, FIFO empty, out_valid=0, out_data=0, overflow=0.
REQ-027 Reset mid-group discards the partial accumulation; the first in_valid after reset is phase 0.
REQ-028 Reset overrides in_valid, out_ready and clr_ovf in the same cycle.

Structure
REQ-029 Package fir_decim_pkg holds the DECIM/FIFO_DEPTH legality checks, the log2 shift constant, and the saturation-limit helper functions.
REQ-030 Output buffer is the sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head), with the same clk and rst.
REQ-031 Accumulator, phase counter, rounding and saturation live in fir_decimator.

Verification (IN_WIDTH=9, DECIM=4, FIFO_DEPTH=4)
REQ-032 Inputs 10,20,30,41 with out_ready=1 -> single out_valid pulse with out_data=25, one cycle after the 4th sample.
REQ-033 Inputs -3,-3,-3,-2 -> out_data=-3. Inputs 255 x4 -> 255. Inputs -256 x4 -> -256.
REQ-034 in_valid gaps of 0..3 idle cycles between the samples in REQ-032 -> identical result 25; no output before the 4th valid sample.
REQ-035 out_ready=0, 20 samples of 8 -> 4 entries of 8 held and overflow=1; then out_ready=1 -> exactly 4 pops; clr_ovf -> overflow=0.
REQ-036 FIFO full, push and pop in the same cycle -> no overflow, occupancy stays 4, pop order preserved.
REQ-037 Samples 100,100, then rst for 1 cycle, then 4,4,4,4 -> out_data=4, and out_valid=0 throughout reset.

Source files
------------

// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: parameter legality checks, shift constant and saturation limits for fir_decimator
package fir_decim_pkg;

    function automatic bit is_pow2(int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction

    function automatic bit decim_ok(int d);
        return is_pow2(d) && d >= 2 && d <= 16;
    endfunction

    function automatic bit depth_ok(int d);
        return is_pow2(d) && d >= 2;
    endfunction

    function automatic int decim_shift(int d);
        return $clog2(d);
    endfunction

    function automatic int sat_max(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; a push while full succeeds only alongside a pop
module sync_fifo
    import fir_decim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr;
    logic             rd;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: averages each group of DECIM valid samples (round half up, saturated) into an output FIFO
module fir_decimator
    import fir_decim_pkg::*;
#(
    parameter int IN_WIDTH   = 9,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [IN_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [IN_WIDTH-1:0] out_data,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int SHIFT = decim_shift(DECIM);
    localparam int ACC_W = IN_WIDTH + SHIFT;
    localparam logic signed [ACC_W:0]    HALF = (ACC_W+1)'(DECIM / 2);
    localparam logic signed [IN_WIDTH:0] SMAX = (IN_WIDTH+1)'(sat_max(IN_WIDTH));
    localparam logic signed [IN_WIDTH:0] SMIN = (IN_WIDTH+1)'(sat_min(IN_WIDTH));

    if (!decim_ok(DECIM)) begin : g_bad_decim
        $error("fir_decimator: DECIM must be a power of two in 2..16");
    end

    logic [SHIFT-1:0]            phase;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W:0]       sum;
    logic signed [ACC_W:0]       rounded;
    logic signed [IN_WIDTH:0]    shifted;
    logic signed [IN_WIDTH-1:0]  result;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic                        drop;

    // phase 0 starts a new group, so the running sum restarts from the sample itself
    always_comb begin
        sum     = (phase == '0 ? '0 : (ACC_W+1)'(acc)) + (ACC_W+1)'(in_data);
        rounded = sum + HALF;
        shifted = (IN_WIDTH+1)'(rounded >>> SHIFT);
        result  = shifted > SMAX ? SMAX[IN_WIDTH-1:0] :
                  shifted < SMIN ? SMIN[IN_WIDTH-1:0] : shifted[IN_WIDTH-1:0];
    end

    assign push      = in_valid && phase == SHIFT'(DECIM - 1);
    assign pop       = !empty && out_ready;
    assign drop      = push && full && !pop;
    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= phase + 1'b1;
                acc   <= ACC_W'(sum);
            end
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end

    sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (result),
        .full  (full),
        .empty (empty),
        .head  (out_data)
    );

endmodule
